debug_uart_tx_fifo: RTL and testbench

Buffered UART transmitter for the MOPSHUB debug path. It accepts bytes over a valid/ready handshake, queues them in a small FIFO, and serializes each one as a standard 8N1 frame: one start bit, eight data bits LSB first, one stop bit, no parity. It is the transmit-side counterpart of `debug_uart_receiver`, with which it must interoperate at the same `c_CLKS_PER_BIT`. It drives host-bound debug/status bytes out of the chip, and benches use it as a serial stimulus source.

---
 rtl/debug_uart_tx_fifo.sv | 152 +++++++++++++++
 tb/tb_debug_uart_tx_fifo.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes enter a small FIFO over a valid/ready
// handshake and are shifted out LSB first with one start and one stop bit.
module debug_uart_tx_fifo #(
    parameter int c_CLKS_PER_BIT = 87,
    parameter int c_FIFO_DEPTH   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_tx_dv,
    input  logic [7:0]                      in_tx_byte,
    output logic                            out_tx_ready,
    output logic [$clog2(c_FIFO_DEPTH):0]   out_fifo_count,
    output logic                            out_tx_serial,
    output logic                            out_tx_active,
    output logic                            out_tx_done,
    output logic                            out_overflow
);
    localparam int c_AW = $clog2(c_FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_TW = $clog2(c_CLKS_PER_BIT);
    localparam logic [c_TW-1:0] c_BIT_LAST  = c_TW'(c_CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(c_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          r_state, w_stateNext;
    logic [7:0]      r_mem [c_FIFO_DEPTH];
    logic [c_AW-1:0] r_wrPtr, r_rdPtr;
    logic [c_CW-1:0] r_count;
    logic [c_TW-1:0] r_clkCnt, w_clkCntNext;
    logic [2:0]      r_bitIdx, w_bitIdxNext, w_bitIdxInc;
    logic [7:0]      r_shift, w_shiftNext;
    logic            r_serial, w_serialNext;
    logic            r_done, w_doneNext;
    logic            r_overflow;
    logic            w_full, w_write, w_pop;

    // Full is judged from the registered count only, so a pop never frees a slot in the same cycle.
    assign w_full      = (r_count == c_DEPTH_CNT);
    assign w_write     = in_tx_dv && !w_full;
    assign w_bitIdxInc = r_bitIdx + 3'd1;

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wrPtr] <= in_tx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)   r_rdPtr <= r_rdPtr + 1'b1;
            if (w_write && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_write) begin
                r_count <= r_count - 1'b1;
            end
            if (in_tx_dv && w_full) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_clkCnt <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_serial <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_clkCnt <= w_clkCntNext;
            r_bitIdx <= w_bitIdxNext;
            r_shift  <= w_shiftNext;
            r_serial <= w_serialNext;
            r_done   <= w_doneNext;
        end
    end

    // The line value for the next bit is chosen here so the serial output comes straight from a flop.
    always_comb begin
        w_stateNext  = r_state;
        w_clkCntNext = r_clkCnt;
        w_bitIdxNext = r_bitIdx;
        w_shiftNext  = r_shift;
        w_serialNext = r_serial;
        w_doneNext   = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                w_serialNext = 1'b1;
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_shiftNext  = r_mem[r_rdPtr];
                    w_clkCntNext = '0;
                    w_serialNext = 1'b0;
                    w_stateNext  = START;
                end
            end
            START: begin
                if (r_clkCnt == c_BIT_LAST) begin
                    w_clkCntNext = '0;
                    w_bitIdxNext = 3'd0;
                    w_serialNext = r_shift[0];
                    w_stateNext  = DATA;
                end else begin
                    w_clkCntNext = r_clkCnt + 1'b1;
                end
            end
            DATA: begin
                if (r_clkCnt == c_BIT_LAST) begin
                    w_clkCntNext = '0;
                    if (r_bitIdx == 3'd7) begin
                        w_bitIdxNext = 3'd0;
                        w_serialNext = 1'b1;
                        w_stateNext  = STOP;
                    end else begin
                        w_bitIdxNext = w_bitIdxInc;
                        w_serialNext = r_shift[w_bitIdxInc];
                    end
                end else begin
                    w_clkCntNext = r_clkCnt + 1'b1;
                end
            end
            STOP: begin
                if (r_clkCnt == c_BIT_LAST) begin
                    w_clkCntNext = '0;
                    w_doneNext   = 1'b1;
                    w_stateNext  = IDLE;
                end else begin
                    w_clkCntNext = r_clkCnt + 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign out_tx_ready   = !w_full;
    assign out_fifo_count = r_count;
    assign out_tx_serial  = r_serial;
    assign out_tx_active  = (r_state != IDLE);
    assign out_tx_done    = r_done;
    assign out_overflow   = r_overflow;

endmodule

// File: tb/tb_debug_uart_tx_fifo.sv
// Randomized and directed bench for debug_uart_tx_fifo: a transaction-level
// model predicts FIFO occupancy and frame timing, a line decoder recovers bytes.
module tb_debug_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_tx_dv = 1'b0;
    logic [7:0] in_tx_byte = 8'h00;
    logic       out_tx_ready, out_tx_serial, out_tx_active, out_tx_done, out_overflow;
    logic [3:0] out_fifo_count;

    logic       inB_dv = 1'b0;
    logic [7:0] inB_byte = 8'h00;
    logic       outB_ready, outB_serial, outB_active, outB_done, outB_overflow;
    logic [3:0] outB_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lastDoneCyc = 0;
    int peak = 0;
    int frameCount = 0;
    int monCnt = -1;
    logic [7:0] monByte = 8'h00;

    logic [7:0] mQ[$];
    logic [7:0] expQ[$];
    int mBusy = 0;
    int mAccepted = 0;
    logic mDone = 1'b0;
    logic mOvf = 1'b0;

    always #5 clk = ~clk;

    debug_uart_tx_fifo #(.c_CLKS_PER_BIT(CPB), .c_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_tx_dv(in_tx_dv), .in_tx_byte(in_tx_byte),
        .out_tx_ready(out_tx_ready), .out_fifo_count(out_fifo_count),
        .out_tx_serial(out_tx_serial), .out_tx_active(out_tx_active),
        .out_tx_done(out_tx_done), .out_overflow(out_overflow)
    );

    debug_uart_tx_fifo dutDefault (
        .clk(clk), .rst(rst), .in_tx_dv(inB_dv), .in_tx_byte(inB_byte),
        .out_tx_ready(outB_ready), .out_fifo_count(outB_count),
        .out_tx_serial(outB_serial), .out_tx_active(outB_active),
        .out_tx_done(outB_done), .out_overflow(outB_overflow)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic dv, input logic [7:0] b);
        in_tx_dv   = dv;
        in_tx_byte = b;
        @(negedge clk);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (!(mQ.size() == 0 && mBusy == 0 && expQ.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idleTimeout", 32'(n >= budget), 0);
        repeat (2) @(negedge clk);
    endtask

    always @(posedge clk) cyc++;

    // Transaction model: the transmitter is busy for a whole frame after each
    // pop and can pop again on any edge where it is not busy.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mQ.delete();
            expQ.delete();
            mBusy = 0;
            mDone = 1'b0;
            mOvf  = 1'b0;
        end else begin
            logic popNow, wrOk;
            mDone  = (mBusy == 1);
            popNow = (mBusy == 0) && (mQ.size() > 0);
            wrOk   = in_tx_dv && (mQ.size() < DEPTH);
            if (in_tx_dv && !wrOk) mOvf = 1'b1;
            if (popNow) begin
                void'(mQ.pop_front());
                mBusy = FRAME;
            end else if (mBusy > 0) begin
                mBusy--;
            end
            if (wrOk) begin
                mQ.push_back(in_tx_byte);
                expQ.push_back(in_tx_byte);
                mAccepted++;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("count", 32'(out_fifo_count), mQ.size());
        checkOutput("ready", 32'(out_tx_ready), 32'(mQ.size() < DEPTH));
        checkOutput("active", 32'(out_tx_active), 32'(mBusy > 0));
        checkOutput("done", 32'(out_tx_done), 32'(mDone));
        checkOutput("overflow", 32'(out_overflow), 32'(mOvf));
        if (mBusy == 0) checkOutput("idleLine", 32'(out_tx_serial), 1);
        if (int'(out_fifo_count) > peak) peak = int'(out_fifo_count);
        if (out_tx_done) lastDoneCyc = cyc;
    end

    // Line decoder: samples each bit at its centre, counted from the first low cycle.
    always @(negedge clk) begin
        if (!rst) begin
            monCnt = -1;
        end else if (monCnt < 0) begin
            if (!out_tx_serial) begin
                monCnt = 0;
                checkOutput("startAlign", mBusy, FRAME);
            end
        end else begin
            monCnt++;
            if (monCnt == CPB / 2) begin
                checkOutput("startBit", 32'(out_tx_serial), 0);
            end else if (monCnt >= CPB + CPB / 2 && monCnt < 9 * CPB && (monCnt - CPB / 2) % CPB == 0) begin
                int idx;
                idx = (monCnt - CPB / 2) / CPB - 1;
                monByte[idx] = out_tx_serial;
            end else if (monCnt == 9 * CPB + CPB / 2) begin
                checkOutput("stopBit", 32'(out_tx_serial), 1);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedFrame", 32'(monByte), 32'h100);
                end else begin
                    checkOutput("rxByte", 32'(monByte), 32'(expQ.pop_front()));
                end
                frameCount++;
                monCnt = -1;
            end
        end
    end

    initial begin
        int base, accBase, writeCyc, n, activeLen, startLen, idx;
        logic [7:0] burst [4];
        logic [7:0] rxB;
        burst[0] = 8'h0A; burst[1] = 8'h0B; burst[2] = 8'h1A; burst[3] = 8'h1B;

        repeat (3) @(negedge clk);
        checkOutput("rstSerial", 32'(out_tx_serial), 1);
        checkOutput("rstReady", 32'(out_tx_ready), 1);
        checkOutput("rstCount", 32'(out_fifo_count), 0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] single byte");
        base = frameCount;
        applyStimulus(1'b1, 8'hA5);
        writeCyc = cyc;
        applyStimulus(1'b0, 8'h00);
        waitIdle(200);
        checkOutput("singleDoneLatency", lastDoneCyc - writeCyc, FRAME + 1);
        checkOutput("singleFrames", frameCount - base, 1);

        $display("[TB] burst");
        base = frameCount;
        peak = 0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, burst[i]);
        applyStimulus(1'b0, 8'h00);
        waitIdle(400);
        checkOutput("burstPeak", peak, 3);
        checkOutput("burstFrames", frameCount - base, 4);

        $display("[TB] overflow");
        base = frameCount;
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 8'(i));
        applyStimulus(1'b0, 8'h00);
        checkOutput("ovfFlag", 32'(out_overflow), 1);
        checkOutput("ovfReady", 32'(out_tx_ready), 0);
        waitIdle(1000);
        checkOutput("ovfFrames", frameCount - base, 9);
        checkOutput("ovfSticky", 32'(out_overflow), 1);

        $display("[TB] write on the done edge");
        base = frameCount;
        applyStimulus(1'b1, 8'h61);
        applyStimulus(1'b1, 8'h62);
        applyStimulus(1'b0, 8'h00);
        n = 0;
        while (!out_tx_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("simulDoneSeen", 32'(n < 200), 1);
        applyStimulus(1'b1, 8'h63);
        checkOutput("simulCount", 32'(out_fifo_count), 1);
        applyStimulus(1'b0, 8'h00);
        waitIdle(400);
        checkOutput("simulFrames", frameCount - base, 3);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 8'h5A);
        applyStimulus(1'b0, 8'h00);
        repeat (17) @(negedge clk);
        checkOutput("preResetActive", 32'(out_tx_active), 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("midRstSerial", 32'(out_tx_serial), 1);
        checkOutput("midRstCount", 32'(out_fifo_count), 0);
        checkOutput("midRstActive", 32'(out_tx_active), 0);
        checkOutput("midRstDone", 32'(out_tx_done), 0);
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        base = frameCount;
        applyStimulus(1'b1, 8'h3C);
        applyStimulus(1'b0, 8'h00);
        waitIdle(200);
        checkOutput("postRstFrames", frameCount - base, 1);

        $display("[TB] random traffic");
        base = frameCount;
        accBase = mAccepted;
        for (int i = 0; i < 400; i++) begin
            if ((i % 100) < 12) applyStimulus(1'b1, 8'($urandom));
            else applyStimulus(logic'($urandom_range(0, 15) == 0), 8'($urandom));
        end
        applyStimulus(1'b0, 8'h00);
        waitIdle(3000);
        checkOutput("randFrames", frameCount - base, mAccepted - accBase);

        $display("[TB] default bit period");
        inB_dv   = 1'b1;
        inB_byte = 8'hFF;
        @(negedge clk);
        inB_dv = 1'b0;
        n = 0;
        while (!outB_active && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("defActiveSeen", 32'(n < 10), 1);
        activeLen = 0;
        startLen  = 0;
        rxB       = 8'h00;
        while (outB_active && activeLen < 2000) begin
            if (!outB_serial && startLen == activeLen) startLen++;
            if (activeLen >= 87 + 43 && activeLen < 870 && ((activeLen - 43) % 87) == 0) begin
                idx = (activeLen - 43) / 87 - 1;
                rxB[idx] = outB_serial;
            end
            activeLen++;
            @(negedge clk);
        end
        checkOutput("defStartLen", startLen, 87);
        checkOutput("defActiveLen", activeLen, 870);
        checkOutput("defRxByte", 32'(rxB), 32'hFF);
        checkOutput("defDone", 32'(outB_done), 1);
        checkOutput("defOverflow", 32'(outB_overflow), 0);

        checkOutput("expQEmpty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
